// File: rtl/state_machine_driver.sv
// Initiator-side driver for the 2-bit state_machine block: mirrors its state, steers it
// to a requested state along a shortest path and flags any observed code mismatch.
module state_machine_driver #(
  parameter logic IDLE_IN = 1'b0,
  parameter int   CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_target_i,
  output logic             in_o,
  input  logic [2:0]       code_i,
  input  logic             err_clr_i,
  output logic             done_o,
  output logic             abort_o,
  output logic             lost_o,
  output logic             err_o,
  output logic [1:0]       mirror_o,
  output logic [1:0]       steps_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [1:0]       state_o
);

  // Handshake: a command transfers on a rising edge where req_valid_i & req_ready_o;
  // req_ready_o is high only in IDLE and does not depend on req_valid_i.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_LOST = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mirror_q, mirror_d;
  logic [1:0]       target_q, target_d;
  logic [1:0]       step_q, step_d;
  logic [1:0]       steps_q, steps_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mismatch;
  logic             count_mismatch;

  function automatic logic [1:0] model_next(input logic [1:0] s, input logic in_b);
    if (!in_b) return s + 2'd1;
    case (s)
      2'd0:    return 2'd2;
      2'd1:    return 2'd3;
      2'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] code_of(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b001;
      2'd3:    return 3'b111;
      default: return 3'b011;
    endcase
  endfunction

  // Shortest-path input toward target t from mirror m; all other pairs step with in=0.
  function automatic logic path_in(input logic [1:0] t, input logic [1:0] m);
    case ({t, m})
      4'b00_01, 4'b01_10, 4'b10_00, 4'b11_01: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  assign mismatch       = (code_i != code_of(mirror_q));
  assign count_mismatch = mismatch && (state_q != ST_LOST);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    step_d      = step_q;
    steps_d     = steps_q;
    in_o        = IDLE_IN;
    req_ready_o = 1'b0;
    done_o      = 1'b0;
    abort_o     = 1'b0;
    lost_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (mismatch) begin
          state_d = ST_LOST;
        end else if (req_valid_i) begin
          target_d = req_target_i;
          step_d   = 2'd0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mirror_q != target_q) in_o = path_in(target_q, mirror_q);
        if (mismatch) begin
          abort_o = 1'b1;
          state_d = ST_LOST;
        end else if (mirror_q == target_q) begin
          done_o  = 1'b1;
          steps_d = step_q;
          state_d = ST_IDLE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: begin
        lost_o = 1'b1;
        in_o   = 1'b0;
        if (code_i == 3'b001) state_d = ST_IDLE;
      end
    endcase
    mirror_d = model_next(mirror_q, in_o);
    // While lost, the only trustworthy anchor is code 001 (state 0); we step past it to 1.
    if (state_q == ST_LOST) mirror_d = (code_i == 3'b001) ? 2'd1 : mirror_q;
  end

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr_i) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
    if (count_mismatch) begin
      err_d = 1'b1;
      if (err_clr_i)   cnt_d = CNT_W'(1);
      else if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      mirror_q <= 2'd0;
      target_q <= 2'd0;
      step_q   <= 2'd0;
      steps_q  <= 2'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mirror_q <= mirror_d;
      target_q <= target_d;
      step_q   <= step_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mirror_o       = mirror_q;
  assign steps_o        = steps_q;
  assign err_o          = err_q;
  assign mismatch_cnt_o = cnt_q;
  assign state_o        = state_q;

  step_limit_a: assert property (@(posedge clk_i) disable iff (!reset_ni) step_q != 2'd3);

endmodule

// File: tb/tb_state_machine_driver.sv
// Directed bench for state_machine_driver against a behavioural target FSM whose code can be overridden.
module tb_state_machine_driver;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic [1:0] req_target_i = 2'd0;
  logic       err_clr_i = 1'b0;
  logic [2:0] code_i;
  logic       force_en = 1'b0;
  logic [2:0] force_code = 3'b000;
  logic [1:0] fsm_s;

  logic       a_ready, a_in, a_done, a_abort, a_lost, a_err;
  logic [1:0] a_mirror, a_steps, a_state;
  logic [7:0] a_cnt;
  logic       b_ready, b_in, b_done, b_abort, b_lost, b_err;
  logic [1:0] b_mirror, b_steps, b_state;
  logic [1:0] b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  state_machine_driver dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_valid_i(req_valid_i), .req_ready_o(a_ready),
    .req_target_i(req_target_i), .in_o(a_in), .code_i(code_i), .err_clr_i(err_clr_i),
    .done_o(a_done), .abort_o(a_abort), .lost_o(a_lost), .err_o(a_err), .mirror_o(a_mirror),
    .steps_o(a_steps), .mismatch_cnt_o(a_cnt), .state_o(a_state)
  );

  state_machine_driver #(.CNT_W(2)) dut_small (
    .clk_i(clk_i), .reset_ni(reset_ni), .req_valid_i(req_valid_i), .req_ready_o(b_ready),
    .req_target_i(req_target_i), .in_o(b_in), .code_i(code_i), .err_clr_i(err_clr_i),
    .done_o(b_done), .abort_o(b_abort), .lost_o(b_lost), .err_o(b_err), .mirror_o(b_mirror),
    .steps_o(b_steps), .mismatch_cnt_o(b_cnt), .state_o(b_state)
  );

  // Behavioural target FSM, reset together with the driver.
  function automatic logic [1:0] tb_next(input logic [1:0] s, input logic in_b);
    logic [1:0] jump [4];
    jump = '{2'd2, 2'd3, 2'd1, 2'd0};
    return in_b ? jump[s] : s + 2'd1;
  endfunction

  function automatic logic [2:0] tb_code(input logic [1:0] s);
    logic [2:0] codes [4];
    codes = '{3'b001, 3'b011, 3'b011, 3'b111};
    return codes[s];
  endfunction

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) fsm_s <= 2'd0;
    else           fsm_s <= tb_next(fsm_s, a_in);
  end

  assign code_i = force_en ? force_code : tb_code(fsm_s);

  task automatic idle_until(input logic [1:0] m);
    bit hit = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i); #1;
      if (fsm_s == m) begin hit = 1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL idle_until: model never reached state %0d", m); end
  endtask

  task automatic test_reset();
    logic [1:0] exp_m [6];
    logic [2:0] exp_c [6];
    exp_m = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_c = '{3'b001, 3'b011, 3'b011, 3'b111, 3'b001, 3'b011};
    #2;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", a_ready); end
    checks++; if (a_in !== 1'b0) begin errors++; $display("FAIL rst_in: got %b want 0", a_in); end
    checks++; if ({a_done, a_abort, a_lost} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {a_done, a_abort, a_lost}); end
    checks++; if ({a_mirror, a_steps, a_err, a_cnt} !== 13'd0) begin errors++; $display("FAIL rst_regs: got %h want 0", {a_mirror, a_steps, a_err, a_cnt}); end
    @(negedge clk_i); reset_ni = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(negedge clk_i); #1; end
      checks++; if (a_mirror !== exp_m[i]) begin errors++; $display("FAIL idle_mirror[%0d]: got %0d want %0d", i, a_mirror, exp_m[i]); end
      checks++; if (code_i !== exp_c[i]) begin errors++; $display("FAIL idle_code[%0d]: got %b want %b", i, code_i, exp_c[i]); end
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL idle_err[%0d]: got %b want 0", i, a_err); end
    end
  endtask

  task automatic test_to_3();
    idle_until(2'd3);
    req_valid_i = 1'b1; req_target_i = 2'd3;
    @(negedge clk_i); req_valid_i = 1'b0; #1;
    checks++; if ({a_ready, a_mirror, a_in, a_done} !== 5'b0_00_0_0) begin errors++; $display("FAIL to3_c1: got %b want 00000", {a_ready, a_mirror, a_in, a_done}); end
    @(negedge clk_i); #1;
    checks++; if ({a_mirror, a_in, a_done} !== 4'b01_1_0) begin errors++; $display("FAIL to3_c2: got %b want 0110", {a_mirror, a_in, a_done}); end
    @(negedge clk_i); #1;
    checks++; if ({a_mirror, a_in, a_done} !== 4'b11_0_1) begin errors++; $display("FAIL to3_c3: got %b want 1101", {a_mirror, a_in, a_done}); end
    @(negedge clk_i); #1;
    checks++; if ({a_ready, a_steps, a_done} !== 4'b1_10_0) begin errors++; $display("FAIL to3_after: got %b want 1100", {a_ready, a_steps, a_done}); end
  endtask

  task automatic test_done_immediate();
    idle_until(2'd1);
    req_valid_i = 1'b1; req_target_i = 2'd2;
    @(negedge clk_i); req_valid_i = 1'b0; #1;
    checks++; if ({a_mirror, a_in, a_done, a_ready} !== 5'b10_0_1_0) begin errors++; $display("FAIL imm_c1: got %b want 10010", {a_mirror, a_in, a_done, a_ready}); end
    @(negedge clk_i); #1;
    checks++; if ({a_ready, a_steps} !== 3'b1_00) begin errors++; $display("FAIL imm_after: got %b want 100", {a_ready, a_steps}); end
  endtask

  task automatic test_to_0();
    idle_until(2'd0);
    req_valid_i = 1'b1; req_target_i = 2'd0;
    @(negedge clk_i); req_valid_i = 1'b0; #1;
    checks++; if ({a_mirror, a_in, a_done} !== 4'b01_1_0) begin errors++; $display("FAIL to0_c1: got %b want 0110", {a_mirror, a_in, a_done}); end
    @(negedge clk_i); #1;
    checks++; if ({a_mirror, a_in, a_done} !== 4'b11_0_0) begin errors++; $display("FAIL to0_c2: got %b want 1100", {a_mirror, a_in, a_done}); end
    @(negedge clk_i); #1;
    checks++; if ({a_mirror, a_done} !== 3'b00_1) begin errors++; $display("FAIL to0_c3: got %b want 001", {a_mirror, a_done}); end
    @(negedge clk_i); #1;
    checks++; if ({a_ready, a_steps} !== 3'b1_10) begin errors++; $display("FAIL to0_after: got %b want 110", {a_ready, a_steps}); end
  endtask

  task automatic test_abort();
    bit seen = 0;
    idle_until(2'd3);
    req_valid_i = 1'b1; req_target_i = 2'd3;
    @(negedge clk_i); req_valid_i = 1'b0; force_en = 1'b1; force_code = 3'b011; #1;
    checks++; if ({a_abort, a_done, a_mirror} !== 4'b1_0_00) begin errors++; $display("FAIL abort_pulse: got %b want 1000", {a_abort, a_done, a_mirror}); end
    @(negedge clk_i); force_code = 3'b111; #1;
    checks++; if ({a_lost, a_err, a_ready, a_in, a_abort} !== 5'b11000) begin errors++; $display("FAIL abort_lost: got %b want 11000", {a_lost, a_err, a_ready, a_in, a_abort}); end
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL abort_cnt: got %0d want 1", a_cnt); end
    checks++; if (a_mirror !== 2'd1) begin errors++; $display("FAIL abort_mirror: got %0d want 1", a_mirror); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i); force_en = 1'b0; #1;
      checks++; if ({a_lost, a_mirror} !== 3'b1_01) begin errors++; $display("FAIL lost_hold[%0d]: got %b want 101", i, {a_lost, a_mirror}); end
      if (fsm_s == 2'd0) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL lost_wait: code 001 never presented"); end
    @(negedge clk_i); #1;
    checks++; if ({a_lost, a_ready, a_mirror, a_err} !== 5'b0_1_01_1) begin errors++; $display("FAIL resync: got %b want 01011", {a_lost, a_ready, a_mirror, a_err}); end
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL resync_cnt: got %0d want 1", a_cnt); end
    err_clr_i = 1'b1;
    @(negedge clk_i); err_clr_i = 1'b0; #1;
    checks++; if ({a_err, a_cnt} !== 9'd0) begin errors++; $display("FAIL err_clr: got %h want 0", {a_err, a_cnt}); end
  endtask

  task automatic test_cnt_sat_and_reset();
    @(negedge clk_i); reset_ni = 1'b0;
    @(negedge clk_i); reset_ni = 1'b1; #1;
    for (int n = 0; n < 5; n++) begin
      bit back = 0;
      force_en = 1'b1; force_code = 3'b000;
      @(negedge clk_i); force_en = 1'b0; #1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk_i); #1;
        if (!a_lost && !b_lost) begin back = 1; break; end
      end
      checks++; if (!back) begin errors++; $display("FAIL sat_resync[%0d]: lost a=%b b=%b want 0", n, a_lost, b_lost); end
    end
    checks++; if (b_cnt !== 2'd3) begin errors++; $display("FAIL sat_small: got %0d want 3", b_cnt); end
    checks++; if (a_cnt !== 8'd5) begin errors++; $display("FAIL sat_wide: got %0d want 5", a_cnt); end
    checks++; if ({a_err, b_err, a_mirror} !== 4'b1_1_01) begin errors++; $display("FAIL sat_state: got %b want 1101", {a_err, b_err, a_mirror}); end
    req_valid_i = 1'b1; req_target_i = 2'd0;
    @(negedge clk_i); req_valid_i = 1'b0; #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL midbusy_pre: got %b want 0", a_ready); end
    reset_ni = 1'b0; #1;
    checks++; if ({a_ready, a_mirror, a_err, a_cnt, a_lost, a_done, a_in} !== 15'b1_00_0_00000000_0_0_0) begin errors++; $display("FAIL midbusy_rst: got %b want 100000000000000", {a_ready, a_mirror, a_err, a_cnt, a_lost, a_done, a_in}); end
    checks++; if ({b_cnt, b_mirror, b_err} !== 5'd0) begin errors++; $display("FAIL midbusy_rst_small: got %b want 00000", {b_cnt, b_mirror, b_err}); end
    @(negedge clk_i); reset_ni = 1'b1;
    @(negedge clk_i); #1;
    checks++; if ({a_mirror, a_ready, a_err} !== 4'b01_1_0) begin errors++; $display("FAIL post_rst: got %b want 0110", {a_mirror, a_ready, a_err}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_to_3();
    test_done_immediate();
    test_to_0();
    test_abort();
    test_cnt_sat_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
